// File: rtl/pwm_capture_scheduler.sv
// Time-shares one PWM capture unit across CHANNELS inputs. Each sweep visits the enabled channels in
// ascending order (settle, trigger, wait, read, clear) and keeps one result per channel with a timeout flag.
module pwm_capture_scheduler #(
  parameter int CHANNELS  = 4,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 1000000,
  parameter int SETTLE    = 2,
  localparam int CW = $clog2(CHANNELS),
  localparam int TW = $clog2(TIMEOUT + 1),
  localparam int SW = $clog2(SETTLE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [CHANNELS-1:0]  ch_enable,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 irq,
  input  logic                 irq_clr,
  input  logic [CW-1:0]        rd_addr,
  output logic [BUS_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_timeout,
  output logic [CW-1:0]        cap_sel,
  output logic                 cap_trigger,
  output logic                 cap_oe,
  input  logic                 cap_int,
  output logic                 cap_int_clr,
  input  logic [BUS_WIDTH-1:0] cap_data,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_TRIG, S_WAIT, S_READ, S_CLEAR, S_TOUT, S_NEXT
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        ch_q;
  logic [CHANNELS-1:0]  mask_q, valid_q, tout_q;
  logic [BUS_WIDTH-1:0] result_q [CHANNELS];
  logic [SW-1:0]        settle_q;
  logic [TW-1:0]        tcnt_q;
  logic                 busy_q, done_q, irq_q, trig_q, oe_q, clr_q;

  logic [CW-1:0] low_ch_d, nxt_ch_d;
  logic          nxt_found_d, sweep_end_d, launch_d;

  // Lowest channel of the live mask (for a sweep start) and next higher channel of the latched mask.
  always_comb begin
    low_ch_d    = '0;
    nxt_ch_d    = '0;
    nxt_found_d = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_enable[i]) low_ch_d = CW'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found_d = 1'b1;
        nxt_ch_d    = CW'(i);
      end
    end
    sweep_end_d = (state_q == S_NEXT) && !nxt_found_d;
    launch_d    = (|ch_enable) &&
                  (((state_q == S_IDLE) && start && !busy_q) || (sweep_end_d && continuous));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      mask_q   <= '0;
      valid_q  <= '0;
      tout_q   <= '0;
      settle_q <= '0;
      tcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      trig_q   <= 1'b0;
      oe_q     <= 1'b0;
      clr_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) result_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      // The set wins both on the sweep-ending edge and while sweep_done is showing.
      if (sweep_end_d) irq_q <= 1'b1;
      else if (irq_clr && !done_q) irq_q <= 1'b0;

      case (state_q)
        S_IDLE: busy_q <= 1'b0;
        S_SETTLE: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            trig_q  <= 1'b1;
            state_q <= S_TRIG;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_TRIG: begin
          trig_q  <= 1'b0;
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cap_int) begin
            oe_q    <= 1'b1;
            state_q <= S_READ;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_TOUT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_READ: begin
          result_q[ch_q] <= cap_data;
          valid_q[ch_q]  <= 1'b1;
          tout_q[ch_q]   <= 1'b0;
          oe_q           <= 1'b0;
          clr_q          <= 1'b1;
          state_q        <= S_CLEAR;
        end
        S_CLEAR: begin
          clr_q   <= 1'b0;
          state_q <= S_NEXT;
        end
        S_TOUT: begin
          result_q[ch_q] <= '0;
          valid_q[ch_q]  <= 1'b1;
          tout_q[ch_q]   <= 1'b1;
          state_q        <= S_NEXT;
        end
        S_NEXT: begin
          if (nxt_found_d) begin
            ch_q     <= nxt_ch_d;
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Fresh start or continuous restart; overrides the IDLE fall-through above.
      if (launch_d) begin
        mask_q   <= ch_enable;
        valid_q  <= valid_q & ~ch_enable;
        tout_q   <= tout_q & ~ch_enable;
        ch_q     <= low_ch_d;
        settle_q <= '0;
        busy_q   <= 1'b1;
        state_q  <= S_SETTLE;
      end
    end
  end

  always_comb begin
    rd_data    = '0;
    rd_valid   = 1'b0;
    rd_timeout = 1'b0;
    if (int'(rd_addr) < CHANNELS) begin
      rd_data    = result_q[rd_addr];
      rd_valid   = valid_q[rd_addr];
      rd_timeout = tout_q[rd_addr];
    end
  end

  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign irq         = irq_q;
  assign cap_sel     = ch_q;
  assign cap_trigger = trig_q;
  assign cap_oe      = oe_q;
  assign cap_int_clr = clr_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/pwm_capture_scheduler.md
Name: pwm_capture_scheduler

Overview:
- Time-shares one PWM capture unit (trigger/oe/int/int_clr/data interface) across CHANNELS external PWM inputs.
- Drives the unit's input-mux select and sequences trigger -> wait for capture interrupt -> read -> clear on each enabled channel in ascending order.
- Stores one result per channel in a readable register file, with per-channel timeout detection.
- Sits between the capture unit and the bus-side register interface; raises one interrupt per completed sweep.

Parameters:
- CHANNELS, 4, number of PWM inputs sharing the capture unit (2..16).
- BUS_WIDTH, 32, width of the capture unit data bus and of each stored result.
- TIMEOUT, 1000000, maximum WAIT cycles per channel before the channel is declared timed out (>=2).
- SETTLE, 2, cycles to hold cap_sel stable before triggering (>=1); covers the input mux and synchroniser.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- continuous  in  1  1 = restart a new sweep automatically after each sweep completes.
- ch_enable  in  CHANNELS  channel mask; latched at each sweep start.
- busy  out  1  high from sweep start until return to IDLE.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.
- irq  out  1  sticky; set at the end of each sweep, cleared by irq_clr.
- irq_clr  in  1  clears irq.
- rd_addr  in  clog2(CHANNELS)  result register select.
- rd_data  out  BUS_WIDTH  stored result for rd_addr; combinational read; 0 when rd_addr >= CHANNELS.
- rd_valid  out  1  valid bit for rd_addr.
- rd_timeout  out  1  timeout bit for rd_addr.
- cap_sel  out  clog2(CHANNELS)  input-mux select feeding ext_pwm of the capture unit.
- cap_trigger  out  1  to capture unit trigger.
- cap_oe  out  1  to capture unit output enable.
- cap_int  in  1  capture unit interrupt flag.
- cap_int_clr  out  1  to capture unit interrupt clear.
- cap_data  in  BUS_WIDTH  capture unit data bus; sampled only while cap_oe = 1.

Behaviour:
- Reset (rst = 0, async): state IDLE; busy, sweep_done, irq, cap_trigger, cap_oe and cap_int_clr = 0; cap_sel = 0; all results = 0; all valid and timeout bits = 0; latched mask = 0; timeout counter = 0. Reset asserted mid-sweep aborts immediately, with no sweep_done and no irq.
- States: IDLE, SETTLE, TRIG, WAIT, READ, CLEAR, TOUT, NEXT.
- IDLE: on start = 1 with ch_enable != 0:
  - latch mask;
  - clear valid and timeout bits of the enabled channels (other channels keep their contents);
  - set ch to the lowest enabled index and cap_sel = ch;
  - go to SETTLE; busy = 1 from the next cycle.
  - start with mask = 0 is ignored. start while busy is ignored.
- SETTLE: hold for exactly SETTLE cycles, then go to TRIG.
- TRIG: cap_trigger = 1 for exactly this one cycle; reset the timeout counter to 0; go to WAIT.
- WAIT: each cycle, check in this order:
  - cap_int = 1 -> READ;
  - else if counter == TIMEOUT-1 -> TOUT;
  - else counter += 1.
  - cap_int wins if it coincides with the last timeout cycle.
- READ: cap_oe = 1 for one cycle; register cap_data into result[ch] at the end of that cycle; valid[ch] = 1, timeout[ch] = 0; go to CLEAR.
- CLEAR: cap_int_clr = 1 for one cycle; go to NEXT.
- TOUT: result[ch] = 0, valid[ch] = 1, timeout[ch] = 1; cap_int_clr is not pulsed; go to NEXT. The next trigger reinitialises the capture unit.
- NEXT, when a higher enabled channel exists in the latched mask: ch = that channel, cap_sel updates, go to SETTLE.
- NEXT, when no higher enabled channel exists:
  - sweep_done = 1 for one cycle and irq = 1;
  - if continuous = 1 and ch_enable != 0, relatch the mask and restart at SETTLE on its lowest channel (with the same valid/timeout clearing as a fresh start);
  - otherwise go to IDLE, with busy = 0 on the following cycle.
  - continuous is sampled only here; deasserting it mid-sweep lets the current sweep finish.
- Changes to ch_enable mid-sweep have no effect until the next sweep start.
- Per-channel overhead outside WAIT is SETTLE + 4 cycles (SETTLE, TRIG, READ, CLEAR, NEXT) for a captured channel.
- irq: a set at sweep end wins over a simultaneous irq_clr.
- cap_oe is never asserted outside READ, so the shared data bus is left undriven by the capture unit otherwise.
- cap_trigger, cap_oe and cap_int_clr are mutually exclusive; at most one is high in any cycle.
- Timeout counter width is clog2(TIMEOUT+1) bits; no wrap is possible.

Test Plan:
- Reset mid-WAIT on channel 2 -> all outputs return to reset values asynchronously, with no sweep_done and no irq; rd_valid = 0 for all addresses.
- ch_enable = 4'b0101, start, capture model returns 37 on ch0 and 1200 on ch2 -> cap_sel sequence 0 then 2; one cap_trigger and one cap_int_clr per channel; rd_addr 0/2 give 37/1200 with valid = 1; rd_addr 1 gives valid = 0; one sweep_done pulse; irq = 1.
- TIMEOUT = 8, ch1 never raises cap_int -> exactly 8 WAIT cycles, then result[1] = 0, timeout[1] = 1, no cap_int_clr for ch1, and the sweep continues to the next enabled channel.
- cap_int asserted on the final timeout cycle (counter = TIMEOUT-1) -> treated as a capture: timeout = 0 and data is stored.
- continuous = 1 with mask 4'b0011 -> back-to-back sweeps with a sweep_done per sweep; deassert continuous during the ch0 WAIT of sweep 3 -> sweep 3 completes and busy falls one cycle after its sweep_done.
- irq_clr pulsed in the same cycle as sweep_done -> irq remains 1; start pulsed while busy -> no effect; start with ch_enable = 0 -> busy stays 0.
